// File: rtl/addr_ctrl_pkg.sv
// rtl/addr_ctrl_pkg.sv - shared types, config codes and period clamp for addr_gen_ctrl
// Purpose : sequencer state type, generator cfg encodings, period clamp helpers.
// Contents: state_e (IDLE/ARM/PRIME/RUN/DONE), CFG_OFF/CFG_RUN/CFG_CAPTURE,
//           clamp_period(), period_bad().
package addr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] CFG_OFF     = 2'b00;
  localparam logic [1:0] CFG_RUN     = 2'b01;
  localparam logic [1:0] CFG_CAPTURE = 2'b11;

  localparam int PERIOD_W_DEF = 32;

  // A period of 0 would stall the generator on address 0; anything above
  // pmax cannot be reached by the generator's address counter.
  function automatic logic [PERIOD_W_DEF-1:0] clamp_period(
    input logic [PERIOD_W_DEF-1:0] p,
    input logic [PERIOD_W_DEF-1:0] pmax
  );
    if (p == '0) return PERIOD_W_DEF'(1);
    if (p > pmax) return pmax;
    return p;
  endfunction

  function automatic logic period_bad(
    input logic [PERIOD_W_DEF-1:0] p,
    input logic [PERIOD_W_DEF-1:0] pmax
  );
    return (p == '0) || (p > pmax);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst (sync, active-high), clr_i (clear), inc_i (increment),
//        count_o (current value), count_next_o (value after one saturating increment).
module sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o,
  output logic [COUNT_W-1:0] count_next_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Sticks at all-ones instead of wrapping to zero.
  assign count_next_o = (&count_q) ? count_q : count_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_next_o;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/addr_gen_ctrl.sv
// rtl/addr_gen_ctrl.sv - acquisition sequencer for the BRAM address generator
// Purpose : latch a clamped period, prime the generator, align capture to the
//           first address wrap, count N periods, then idle the generator.
// Macro   : ADDR_CTRL_EXT_TRIG_EN adds the trig port and the ARM state.
// Ports   : clk, rst (sync, active-high); start, abort, period_in, n_periods,
//           [trig]; gen_restart, gen_addr, gen_tvalid from the generator;
//           gen_cfg, gen_period to the generator; wen to the BRAM; busy, done,
//           periods_done, err_period status.
module addr_gen_ctrl
  import addr_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic [COUNT_W-1:0]  n_periods,
`ifdef ADDR_CTRL_EXT_TRIG_EN
  input  logic                trig,
`endif
  input  logic                gen_restart,
  input  logic [WIDTH+1:0]    gen_addr,
  input  logic                gen_tvalid,
  output logic [1:0]          gen_cfg,
  output logic [PERIOD_W-1:0] gen_period,
  output logic                wen,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  periods_done,
  output logic                err_period
);

  localparam logic [PERIOD_W-1:0] PMAX       = PERIOD_W'((64'd1 << (WIDTH + 2)) - 64'd1);
  localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'((64'd1 << WIDTH) - 64'd1);

  state_e                state_q;
  logic [1:0]            gen_cfg_q;
  logic [PERIOD_W-1:0]   gen_period_q;
  logic [COUNT_W-1:0]    n_q;
  logic                  done_q;
  logic                  err_q;
  logic [COUNT_W-1:0]    cnt_next;
  logic                  trig_rise;
  logic                  start_accept;
  logic                  run_restart;
  logic [PERIOD_W_DEF-1:0] period_ext;
  logic                  unused_gen_addr;

  // The address is only useful for debug probing here.
  assign unused_gen_addr = ^gen_addr;

  assign period_ext   = PERIOD_W_DEF'(period_in);
  // abort outranks both a start and a restart landing in the same cycle.
  assign start_accept = (state_q == IDLE) && start && !abort;
  assign run_restart  = (state_q == RUN) && gen_restart && !abort;

`ifdef ADDR_CTRL_EXT_TRIG_EN
  logic trig_prev_q;
  always_ff @(posedge clk) begin
    if (rst) trig_prev_q <= 1'b0;
    else     trig_prev_q <= trig;
  end
  assign trig_rise = trig && !trig_prev_q;
`else
  assign trig_rise = 1'b0;
`endif

  sat_counter #(.COUNT_W(COUNT_W)) u_periods (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_accept),
    .inc_i        (run_restart),
    .count_o      (periods_done),
    .count_next_o (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gen_cfg_q    <= CFG_OFF;
      gen_period_q <= PERIOD_RST;
      n_q          <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        gen_cfg_q <= CFG_OFF;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              gen_period_q <= PERIOD_W'(clamp_period(period_ext, PERIOD_W_DEF'(PMAX)));
              err_q        <= period_bad(period_ext, PERIOD_W_DEF'(PMAX));
              n_q          <= n_periods;
`ifdef ADDR_CTRL_EXT_TRIG_EN
              state_q      <= ARM;
              gen_cfg_q    <= CFG_OFF;
`else
              state_q      <= PRIME;
              gen_cfg_q    <= CFG_RUN;
`endif
            end
          end
          ARM: begin
            if (trig_rise) begin
              state_q   <= PRIME;
              gen_cfg_q <= CFG_RUN;
            end
          end
          PRIME: begin
            // The first wrap marks address 0 of the next cycle: capture starts there.
            if (gen_restart) begin
              state_q   <= RUN;
              gen_cfg_q <= CFG_CAPTURE;
            end
          end
          RUN: begin
            if (gen_restart && (n_q != '0) && (cnt_next == n_q)) begin
              state_q   <= DONE;
              gen_cfg_q <= CFG_OFF;
              done_q    <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q   <= IDLE;
            gen_cfg_q <= CFG_OFF;
          end
        endcase
      end
    end
  end

  assign gen_cfg    = gen_cfg_q;
  assign gen_period = gen_period_q;
  assign done       = done_q;
  assign err_period = err_q;
  assign busy       = (state_q != IDLE);
  // Qualified live with gen_tvalid so each write lines up with its address.
  assign wen        = (state_q == RUN) && gen_tvalid && gen_cfg_q[1];

endmodule

// File: tb/tb_addr_gen_ctrl.sv
// tb/tb_addr_gen_ctrl.sv - self-checking bench for addr_gen_ctrl with a generator model
module tb_addr_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] period_in;
  logic [15:0] n_periods;
`ifdef ADDR_CTRL_EXT_TRIG_EN
  logic        trig;
`endif
  logic        gen_restart;
  logic [9:0]  gen_addr;
  logic        gen_tvalid;
  logic [1:0]  gen_cfg;
  logic [31:0] gen_period;
  logic        wen;
  logic        busy;
  logic        done;
  logic [15:0] periods_done;
  logic        err_period;

  int n_cmp = 0;
  int n_bad = 0;
  int wen_total = 0;
  int done_total = 0;
  int rst_total = 0;

  always #5 clk = ~clk;

  addr_gen_ctrl #(.WIDTH(8), .PERIOD_W(32), .COUNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .period_in    (period_in),
    .n_periods    (n_periods),
`ifdef ADDR_CTRL_EXT_TRIG_EN
    .trig         (trig),
`endif
    .gen_restart  (gen_restart),
    .gen_addr     (gen_addr),
    .gen_tvalid   (gen_tvalid),
    .gen_cfg      (gen_cfg),
    .gen_period   (gen_period),
    .wen          (wen),
    .busy         (busy),
    .done         (done),
    .periods_done (periods_done),
    .err_period   (err_period)
  );

  // Address generator: counts 0..gen_period while enabled, pulses restart on the last address.
  logic [9:0] gaddr = '0;
  assign gen_tvalid  = gen_cfg[0];
  assign gen_restart = gen_cfg[0] && ({22'd0, gaddr} == gen_period);
  assign gen_addr    = gaddr;
  always @(posedge clk) begin
    if (!gen_cfg[0] || gen_restart) gaddr <= '0;
    else                            gaddr <= gaddr + 10'd1;
  end

  always @(posedge clk) begin
    if (wen)         wen_total++;
    if (done)        done_total++;
    if (gen_restart) rst_total++;
  end

  function automatic int unsigned exp_period(input int unsigned p);
    if (p == 0) return 1;
    if (p > 1023) return 1023;
    return p;
  endfunction

  function automatic bit exp_err(input int unsigned p);
    return (p == 0) || (p > 1023);
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
`ifdef ADDR_CTRL_EXT_TRIG_EN
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
`endif
  endtask

  task automatic do_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (gen_cfg !== 2'b00 || gen_period !== 32'd255 || wen !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || periods_done !== 16'd0 || err_period !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vals: cfg=%0d period=%0d wen=%0d busy=%0d done=%0d pd=%0d err=%0d, expected 0/255/0/0/0/0/0",
               gen_cfg, gen_period, wen, busy, done, periods_done, err_period);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || gen_cfg !== 2'b00 || gen_period !== 32'd255) begin
        n_bad++;
        $display("FAIL idle_after_reset: cycle %0d busy=%0d cfg=%0d period=%0d, expected 0/0/255", i, busy, gen_cfg, gen_period);
      end
    end
  endtask

  task automatic test_capture(input int unsigned p, input int unsigned n);
    int wb, db, rb;
    bit seen;
    period_in = p;
    n_periods = 16'(n);
    wb = wen_total; db = done_total; rb = rst_total;
    do_start();
    n_cmp++;
    if (gen_cfg !== 2'b01 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL capture_prime: p=%0d cfg=%0d busy=%0d, expected 1/1", p, gen_cfg, busy);
    end
    seen = 1'b0;
    for (int i = 0; i <= int'(p) + 4; i++) begin
      if (gen_restart === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (!seen || gen_cfg !== 2'b11) begin
      n_bad++;
      $display("FAIL capture_run: p=%0d restart_seen=%0d cfg=%0d, expected 1/3", p, seen, gen_cfg);
    end
    seen = 1'b0;
    for (int i = 0; i <= int'((n + 1) * (p + 1)) + 20; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL capture_done_timeout: p=%0d n=%0d done never seen, expected a done pulse", p, n);
    end
    n_cmp++;
    if (rst_total - rb != int'(n + 1) || wen_total - wb != int'(n * (p + 1)) || periods_done !== 16'(n)) begin
      n_bad++;
      $display("FAIL capture_counts: p=%0d n=%0d restarts=%0d wen=%0d pd=%0d, expected %0d/%0d/%0d",
               p, n, rst_total - rb, wen_total - wb, periods_done, n + 1, n * (p + 1), n);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || gen_cfg !== 2'b00 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL capture_idle: busy=%0d cfg=%0d done=%0d, expected 0/0/0", busy, gen_cfg, done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_total - db != 1 || periods_done !== 16'(n) || gen_period !== p) begin
      n_bad++;
      $display("FAIL capture_hold: done_pulses=%0d pd=%0d period=%0d, expected 1/%0d/%0d",
               done_total - db, periods_done, gen_period, n, p);
    end
  endtask

  task automatic test_clamp();
    int unsigned vals[10];
    vals[0] = 5000; vals[1] = 100; vals[2] = 0; vals[3] = 1023; vals[4] = 1024;
    for (int i = 5; i < 9; i++) vals[i] = $urandom_range(0, 3000);
    vals[9] = $urandom;
    n_periods = 16'd0;
    for (int i = 0; i < 10; i++) begin
      period_in = vals[i];
      do_start();
      n_cmp++;
      if (gen_period !== exp_period(vals[i]) || err_period !== exp_err(vals[i])) begin
        n_bad++;
        $display("FAIL clamp: in=%0d period=%0d err=%0d, expected %0d/%0d",
                 vals[i], gen_period, err_period, exp_period(vals[i]), exp_err(vals[i]));
      end
      do_abort();
    end
  endtask

  task automatic test_continuous_abort();
    int unsigned p;
    int cnt, db;
    p = $urandom_range(3, 20);
    period_in = p;
    n_periods = 16'd0;
    db = done_total;
    do_start();
    cnt = 0;
    for (int i = 0; i < 12 * int'(p + 1) + 20; i++) begin
      if (gen_restart === 1'b1) cnt++;
      if (cnt == 11) break;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 11) begin
      n_bad++;
      $display("FAIL cont_restarts: restarts=%0d, expected 11", cnt);
    end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || gen_cfg !== 2'b00 || done !== 1'b0 || periods_done !== 16'd10) begin
      n_bad++;
      $display("FAIL cont_abort: busy=%0d cfg=%0d done=%0d pd=%0d, expected 0/0/0/10", busy, gen_cfg, done, periods_done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_total != db) begin
      n_bad++;
      $display("FAIL cont_no_done: done pulses=%0d, expected 0", done_total - db);
    end
  endtask

  task automatic test_abort_final();
    int unsigned p;
    int cnt, db;
    p = $urandom_range(2, 20);
    period_in = p;
    n_periods = 16'd2;
    db = done_total;
    do_start();
    cnt = 0;
    for (int i = 0; i < 4 * int'(p + 1) + 20; i++) begin
      if (gen_restart === 1'b1) cnt++;
      if (cnt == 3) begin abort = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk); abort = 1'b0;
    n_cmp++;
    if (cnt != 3 || busy !== 1'b0 || done !== 1'b0 || gen_cfg !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_final: restarts=%0d busy=%0d done=%0d cfg=%0d, expected 3/0/0/0", cnt, busy, done, gen_cfg);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_total != db) begin
      n_bad++;
      $display("FAIL abort_final_no_done: done pulses=%0d, expected 0", done_total - db);
    end
  endtask

  task automatic test_start_while_busy();
    int unsigned p;
    int db;
    p = $urandom_range(20, 60);
    period_in = p;
    n_periods = 16'd0;
    db = done_total;
    do_start();
    for (int i = 0; i < int'(p) + 5; i++) begin
      if (gen_restart === 1'b1) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    period_in = 15;
    n_periods = 16'd1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (gen_period !== p || busy !== 1'b1 || gen_cfg !== 2'b11 || err_period !== 1'b0) begin
      n_bad++;
      $display("FAIL start_busy: period=%0d busy=%0d cfg=%0d err=%0d, expected %0d/1/3/0", gen_period, busy, gen_cfg, err_period, p);
    end
    // The latched n=0 must keep running past a restart that would end an n=1 capture.
    repeat (2 * int'(p + 1)) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done_total != db) begin
      n_bad++;
      $display("FAIL start_busy_n: busy=%0d done pulses=%0d, expected 1/0", busy, done_total - db);
    end
    do_abort();
  endtask

  task automatic test_reset_mid_run();
    int db;
    period_in = 30;
    n_periods = 16'd1;
    db = done_total;
    do_start();
    for (int i = 0; i < 40; i++) begin
      if (gen_restart === 1'b1) break;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (gen_cfg !== 2'b00 || gen_period !== 32'd255 || busy !== 1'b0 || done !== 1'b0 || periods_done !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_mid_run: cfg=%0d period=%0d busy=%0d done=%0d pd=%0d, expected 0/255/0/0/0",
               gen_cfg, gen_period, busy, done, periods_done);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_total != db) begin
      n_bad++;
      $display("FAIL reset_mid_run_done: done pulses=%0d, expected 0", done_total - db);
    end
  endtask

`ifdef ADDR_CTRL_EXT_TRIG_EN
  task automatic test_trig();
    period_in = 50;
    n_periods = 16'd0;
    trig = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || gen_cfg !== 2'b00) begin
        n_bad++;
        $display("FAIL trig_arm: cycle %0d busy=%0d cfg=%0d, expected 1/0", i, busy, gen_cfg);
      end
      @(negedge clk);
    end
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    n_cmp++;
    if (gen_cfg !== 2'b01) begin
      n_bad++;
      $display("FAIL trig_prime: cfg=%0d, expected 1", gen_cfg);
    end
    do_abort();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; period_in = '0; n_periods = '0;
`ifdef ADDR_CTRL_EXT_TRIG_EN
    trig = 1'b0;
`endif
    test_reset();
    test_capture(255, 3);
    test_capture(10, 1);
    for (int k = 0; k < 3; k++) test_capture($urandom_range(1, 40), $urandom_range(1, 4));
    test_clamp();
    test_continuous_abort();
    test_abort_final();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef ADDR_CTRL_EXT_TRIG_EN
    test_trig();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
